// File: rtl/avalon_mm_pkg.sv
// Shared types and constants for the Avalon-MM bring-up initiator and the
// register block it talks to.
package avalon_mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT
    } state_t;

    // Register map of avalon_mm_slave.
    localparam logic [15:0] REG_SEND_PACKET = 16'h0050;
    localparam logic [15:0] REG_TEST        = 16'h0010;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/avalon_mm_master.sv
// Single-outstanding Avalon-MM initiator: one host request becomes one
// read/write transfer and exactly one response pulse (data or timeout).
module avalon_mm_master
    import avalon_mm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        avalon_mm_write,
    output logic        avalon_mm_read,
    output logic [15:0] avalon_mm_addr,
    output logic [31:0] avalon_mm_write_data,
    input  logic        avalon_mm_waitrequest,
    input  logic [31:0] avalon_mm_read_data,
    input  logic        avalon_mm_rd_valid
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic              r_read;
    logic [15:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_rsp_valid;
    logic              r_rsp_timeout;
    logic [31:0]       r_rsp_rdata;

    logic              w_expire;
    logic [CNT_W-1:0]  w_cnt_next;

    // Expiry is judged on the count before this edge's increment, so the
    // timeout response lands exactly TIMEOUT_CYCLES edges after acceptance.
    assign w_expire   = (r_cnt >= CNT_LAST);
    assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    assign req_ready            = (r_state == ST_IDLE);
    assign rsp_valid            = r_rsp_valid;
    assign rsp_rdata            = r_rsp_rdata;
    assign rsp_timeout          = r_rsp_timeout;
    assign avalon_mm_write      = r_write;
    assign avalon_mm_read       = r_read;
    assign avalon_mm_addr       = r_addr;
    assign avalon_mm_write_data = r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_write       <= 1'b0;
            r_read        <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= '0;
                        if (req_write) begin
                            r_write <= 1'b1;
                            r_state <= ST_WR;
                        end else begin
                            r_read  <= 1'b1;
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    r_cnt <= w_cnt_next;
                    if (!avalon_mm_waitrequest) begin
                        r_write     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (w_expire) begin
                        r_write       <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= TIMEOUT_RDATA;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    // rd_valid deliberately ignored here: some slaves hold it
                    // high whenever read is asserted.
                    r_cnt <= w_cnt_next;
                    if (!avalon_mm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= ST_RD_WAIT;
                    end else if (w_expire) begin
                        r_read        <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= TIMEOUT_RDATA;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (avalon_mm_rd_valid) begin
                        r_rsp_rdata <= avalon_mm_read_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else if (w_expire) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= TIMEOUT_RDATA;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mm_master.sv
// Bench for avalon_mm_master with a small behavioural register-slave model
// and a response scoreboard (timeout flag, read data, arrival cycle).
module tb_avalon_mm_master;
    import avalon_mm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        avalon_mm_write;
    logic        avalon_mm_read;
    logic [15:0] avalon_mm_addr;
    logic [31:0] avalon_mm_write_data;
    logic        wait_r = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        s_rdv = 1'b0;
    logic        force_rdv = 1'b0;
    logic        slave_mute = 1'b0;
    logic        w_rd_valid;

    logic [31:0] reg_test = 32'hFF0F_F423;
    logic [31:0] reg_send = '0;
    logic        send_cmd = 1'b0;
    logic [7:0]  start_ram_addr = '0;

    typedef struct {
        logic        to;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata = '0;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    assign w_rd_valid = s_rdv | force_rdv;

    avalon_mm_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_write            (req_write),
        .req_addr             (req_addr),
        .req_wdata            (req_wdata),
        .rsp_valid            (rsp_valid),
        .rsp_rdata            (rsp_rdata),
        .rsp_timeout          (rsp_timeout),
        .avalon_mm_write      (avalon_mm_write),
        .avalon_mm_read       (avalon_mm_read),
        .avalon_mm_addr       (avalon_mm_addr),
        .avalon_mm_write_data (avalon_mm_write_data),
        .avalon_mm_waitrequest(wait_r),
        .avalon_mm_read_data  (s_rdata),
        .avalon_mm_rd_valid   (w_rd_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register slave, read latency 1.
    always @(posedge clk) begin
        s_rdv <= 1'b0;
        if (avalon_mm_read && !wait_r && !slave_mute) begin
            s_rdv   <= 1'b1;
            s_rdata <= (avalon_mm_addr == REG_TEST) ? reg_test :
                       (avalon_mm_addr == REG_SEND_PACKET) ? reg_send : 32'h0;
        end
        if (avalon_mm_write && !wait_r && avalon_mm_addr == REG_SEND_PACKET) begin
            reg_send       <= avalon_mm_write_data;
            send_cmd       <= 1'b1;
            start_ram_addr <= avalon_mm_write_data[15:8];
        end
    end

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rsp: cyc=%0d timeout=%b rdata=%h, no response expected",
                         cyc, rsp_timeout, rsp_rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_timeout !== e.to || rsp_rdata !== e.rd || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL rsp: got timeout=%b rdata=%h cyc=%0d, expected timeout=%b rdata=%h cyc=%0d",
                             rsp_timeout, rsp_rdata, cyc, e.to, e.rd, e.cyc);
                end
            end
        end
    end

    task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input int lat, input logic to, input logic [31:0] exp_rd,
                        input bit push, output int acc);
        int n = 0;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            fails++;
            $display("FAIL accept: req_ready=%b after %0d cycles, required 1", req_ready, n);
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (push) begin
            if (to)      model_rdata = TIMEOUT_RDATA;
            else if (!w) model_rdata = exp_rd;
            e.to  = to;
            e.rd  = model_rdata;
            e.cyc = acc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({avalon_mm_write, avalon_mm_read, rsp_valid, rsp_timeout} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_strobes: got %b, required 0000",
                     {avalon_mm_write, avalon_mm_read, rsp_valid, rsp_timeout});
        end
        checks++;
        if (avalon_mm_addr !== 16'h0 || avalon_mm_write_data !== 32'h0 || rsp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, required all 0",
                     avalon_mm_addr, avalon_mm_write_data, rsp_rdata);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b, required 1", req_ready);
        end
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_write;
        int acc;
        send(1'b1, REG_SEND_PACKET, 32'h0000_2A20, 1, 1'b0, 32'h0, 1'b1, acc);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (avalon_mm_write !== 1'b1 || avalon_mm_addr !== REG_SEND_PACKET ||
            avalon_mm_write_data !== 32'h0000_2A20) begin
            fails++;
            $display("FAIL write_strobe: write=%b addr=%h data=%h, required 1/0050/00002a20",
                     avalon_mm_write, avalon_mm_addr, avalon_mm_write_data);
        end
        @(negedge clk);
        checks++;
        if (avalon_mm_write !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL write_drop: write=%b ready=%b, required 0/1", avalon_mm_write, req_ready);
        end
        checks++;
        if (send_cmd !== 1'b1 || start_ram_addr !== 8'h2A) begin
            fails++;
            $display("FAIL write_slave: send_cmd=%b start_ram_addr=%h, required 1/2a",
                     send_cmd, start_ram_addr);
        end
        idle_cycles(2);
    endtask

    task automatic test_read;
        int acc;
        send(1'b0, REG_TEST, 32'h0, 2, 1'b0, 32'hFF0F_F423, 1'b1, acc);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (avalon_mm_read !== 1'b1 || avalon_mm_addr !== REG_TEST) begin
            fails++;
            $display("FAIL read_strobe: read=%b addr=%h, required 1/0010", avalon_mm_read, avalon_mm_addr);
        end
        @(negedge clk);
        checks++;
        if (avalon_mm_read !== 1'b0) begin
            fails++;
            $display("FAIL read_drop: read=%b, required 0", avalon_mm_read);
        end
        idle_cycles(3);
        send(1'b0, REG_SEND_PACKET, 32'h0, 2, 1'b0, 32'h0000_2A20, 1'b1, acc);
        @(negedge clk);
        req_valid = 1'b0;
        idle_cycles(4);
    endtask

    task automatic test_write_stall;
        int acc;
        wait_r = 1'b1;
        send(1'b1, REG_SEND_PACKET, 32'h0000_1234, 4, 1'b0, 32'h0, 1'b1, acc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            checks++;
            if (avalon_mm_write !== 1'b1 || avalon_mm_addr !== REG_SEND_PACKET ||
                avalon_mm_write_data !== 32'h0000_1234) begin
                fails++;
                $display("FAIL stall_hold[%0d]: write=%b addr=%h data=%h, required 1/0050/00001234",
                         i, avalon_mm_write, avalon_mm_addr, avalon_mm_write_data);
            end
            if (i == 3) wait_r = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (avalon_mm_write !== 1'b0) begin
            fails++;
            $display("FAIL stall_drop: write=%b, required 0", avalon_mm_write);
        end
        idle_cycles(2);
    endtask

    task automatic test_timeout;
        int acc;
        slave_mute = 1'b1;
        send(1'b0, REG_TEST, 32'h0, 8, 1'b1, 32'h0, 1'b1, acc);
        @(negedge clk);
        req_valid = 1'b0;
        idle_cycles(9);
        force_rdv = 1'b1;
        @(negedge clk);
        force_rdv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL late_rdv[%0d]: rsp_valid=%b, required 0", i, rsp_valid);
            end
        end
        checks++;
        if (rsp_rdata !== TIMEOUT_RDATA) begin
            fails++;
            $display("FAIL timeout_hold: rdata=%h, required deadbeef", rsp_rdata);
        end
        slave_mute = 1'b0;
    endtask

    task automatic test_reset_mid;
        int acc;
        slave_mute = 1'b1;
        send(1'b0, REG_TEST, 32'h0, 0, 1'b0, 32'h0, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        model_rdata = '0;
        #1;
        checks++;
        if (avalon_mm_read !== 1'b0 || avalon_mm_write !== 1'b0 || req_ready !== 1'b1 ||
            rsp_valid !== 1'b0 || avalon_mm_addr !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid: read=%b write=%b ready=%b rsp=%b addr=%h, required 0/0/1/0/0000",
                     avalon_mm_read, avalon_mm_write, req_ready, rsp_valid, avalon_mm_addr);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        slave_mute = 1'b0;
        idle_cycles(2);
        send(1'b1, REG_SEND_PACKET, 32'h5555_0000, 1, 1'b0, 32'h0, 1'b1, acc);
        @(negedge clk);
        req_valid = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_back_to_back;
        int acc[4];
        for (int i = 0; i < 4; i++)
            send(1'b1, REG_SEND_PACKET, 32'h0000_0100 * (i + 1), 1, 1'b0, 32'h0, 1'b1, acc[i]);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc[i] - acc[0] != 2 * i) begin
                fails++;
                $display("FAIL b2b_accept[%0d]: spacing=%0d, required %0d", i, acc[i] - acc[0], 2 * i);
            end
        end
        idle_cycles(3);
        checks++;
        if (reg_send !== 32'h0000_0400) begin
            fails++;
            $display("FAIL b2b_last: slave reg=%h, required 00000400", reg_send);
        end
    endtask

    initial begin
        int n = 0;
        test_reset;
        test_write;
        test_read;
        test_write_stall;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/avalon_mm_master.md
# avalon_mm_master

Single-outstanding Avalon-MM initiator that turns one-at-a-time host requests (address, write flag, write data) into Avalon-MM read/write transfers. It drives the `avalon_mm_slave` register block from the test/bring-up side: `send_cmd` writes to 0x0050 and probe reads of 0x0010. Transfers complete on `waitrequest`/`readdatavalid`, and a cycle-bounded timeout guards against a hung slave. Each request returns exactly one response pulse, carrying read data or a timeout flag.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in a bus state (WR, RD, RD_WAIT) before the transfer is aborted; legal range 1..65535.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  block can accept; equals (state == IDLE).
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  target address.
- `req_wdata`  in  32  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  read data, valid with `rsp_valid`; holds its value until the next response.
- `rsp_timeout`  out  1  qualifies `rsp_valid`; 1 = transfer aborted.
- `avalon_mm_write`  out  1  write strobe.
- `avalon_mm_read`  out  1  read strobe.
- `avalon_mm_addr`  out  16  transfer address.
- `avalon_mm_write_data`  out  32  write data.
- `avalon_mm_waitrequest`  in  1  slave stall; tie to 0 for slaves without stall.
- `avalon_mm_read_data`  in  32  read data.
- `avalon_mm_rd_valid`  in  1  read data valid.

## Operation
- **State machine:** IDLE, WR, RD, RD_WAIT.
- **IDLE:**
  - A handshake (`req_valid` & `req_ready`) registers `req_addr` and `req_wdata` onto the Avalon outputs.
  - Next state: WR if `req_write`, else RD. The timeout counter clears to 0.
- **WR:**
  - `avalon_mm_write` = 1; address and data held stable.
  - On a sampled edge with `waitrequest` = 0: strobe drops, `rsp_valid` = 1 with `rsp_timeout` = 0, next state IDLE.
- **RD:**
  - `avalon_mm_read` = 1; address held stable.
  - On a sampled edge with `waitrequest` = 0: strobe drops, next state RD_WAIT.
  - `rd_valid` is ignored in RD, because a slave that asserts `rd_valid` every cycle that `read` is high must not complete the transfer early.
- **RD_WAIT:**
  - On the first sampled `rd_valid`: `rsp_rdata` = `avalon_mm_read_data`, `rsp_valid` = 1, `rsp_timeout` = 0, next state IDLE.
  - Any later `rd_valid` seen in IDLE is discarded.
- **Timeout:**
  - The counter increments on every cycle spent in WR, RD or RD_WAIT.
  - When it reaches `TIMEOUT_CYCLES` with no completion, the strobes drop and `rsp_valid` = 1 with `rsp_timeout` = 1, `rsp_rdata` = `TIMEOUT_RDATA` (32'hDEAD_BEEF).
  - Next state IDLE.
  - If completion and expiry fall on the same edge, completion wins (`rsp_timeout` = 0).
- **Counter width:** `$clog2(TIMEOUT_CYCLES+1)`. The counter saturates and never wraps.
- **Reset** (including mid-transfer): all strobes 0, state IDLE, counter 0, no response generated for the aborted request.

## Timing
- **Reset values:**
  - `avalon_mm_write`, `avalon_mm_read`, `rsp_valid`, `rsp_timeout` = 0.
  - `avalon_mm_addr` = 0, `avalon_mm_write_data` = 0, `rsp_rdata` = 0.
  - `req_ready` = 1.
- **Registered outputs:** all outputs are registered except `req_ready`.
- **Write latency:** with no stall, accept at edge E0 → `write` high E0..E1 → `rsp_valid` E1..E2. Each stall cycle adds one cycle.
- **Read latency:** with no stall and a slave of read latency L ≥ 1, accept at E0 → `read` high for exactly one cycle (E0..E1) → `rsp_valid` at E(L+1)..E(L+2).
- **Back-to-back requests:** `req_ready` is high in the same cycle as `rsp_valid`. A new request accepted then starts its strobe in the next cycle, so a new request can follow every 2 cycles for writes.
- **Stable outputs:** `avalon_mm_addr` and `avalon_mm_write_data` change only on acceptance.

## Structure
- **Package `avalon_mm_pkg`:**
  - State enum.
  - Register address constants `REG_SEND_PACKET` = 16'h0050 and `REG_TEST` = 16'h0010.
  - `TIMEOUT_RDATA` constant.
  - The slave's address defines migrate to this package.
- **Sub-modules:** none. The FSM and timeout counter are inline.

## Test plan
- **Write, no stall:** write 0x0050 / 0x0000_2A20 against `avalon_mm_slave`, `waitrequest` = 0 → `write` high exactly 1 cycle, `rsp_valid` 1 cycle later with `rsp_timeout` = 0; slave shows `send_cmd` = 1, `start_ram_addr` = 0x2A.
- **Read, slave latency 1:** read 0x0010 → `read` high 1 cycle, `rsp_valid` 2 cycles after acceptance, `rsp_rdata` = 0xFF0F_F423; a read of 0x0050 afterwards returns 0x0000_2A20.
- **Write with stall:** `waitrequest` held high for 3 cycles → `write`, `addr` and `data` stable for 4 cycles, `rsp_valid` on the cycle after release.
- **Read timeout:** `TIMEOUT_CYCLES` = 8, slave never asserts `rd_valid` → `rsp_valid` with `rsp_timeout` = 1 and `rsp_rdata` = 0xDEAD_BEEF exactly 8 cycles after acceptance; a late `rd_valid` then produces no response.
- **Reset mid-transfer:** assert `rst_n` low while in RD_WAIT → strobes 0 and `req_ready` = 1 immediately, no `rsp_valid`; the next request completes normally.
- **Back-to-back writes:** `req_valid` held high with 4 writes → each accepted on the cycle its predecessor's `rsp_valid` is high, 4 responses in 8 cycles.
